hazard_ctrl: RTL

Central pipeline controller for the 5-stage MIPS core.
- Generates forwarding selects for the decode and execute stages.
- Produces per-stage stall and flush controls, covering load-use and branch-operand hazards.
- Freezes the whole pipeline on I-cache/D-cache misses.
- Arbitrates the single refill port between the two caches through a miss FSM.
- Sits beside the datapath; its outputs drive the stage registers and muxes.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/miss_arbiter.sv | 56 +++++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and miss-FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    I_MISS  = 2'b01,
    D_MISS  = 2'b10,
    ID_MISS = 2'b11
  } miss_state_e;

endpackage

// File: rtl/miss_arbiter.sv
// Miss FSM: arbitrates the single refill port between I-cache and D-cache, D first.
// Latency: grants are Moore (one cycle after the miss); freeze is combinational.
// Backpressure: freeze holds the whole pipeline until the owning refill reports done.
module miss_arbiter
  import hazard_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic imiss_i,
  input  logic dmiss_i,
  input  logic idone_i,
  input  logic ddone_i,
  output logic igrant_o,
  output logic dgrant_o,
  output logic freeze_o
);

  miss_state_e state_q, state_d;

  // State register; reset drops straight back to RUN even mid-refill.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state and Moore grants; a done pulse only counts for the side holding the grant.
  always_comb begin
    state_d  = state_q;
    igrant_o = 1'b0;
    dgrant_o = 1'b0;
    case (state_q)
      RUN: begin
        if (imiss_i && dmiss_i) state_d = ID_MISS;
        else if (dmiss_i)       state_d = D_MISS;
        else if (imiss_i)       state_d = I_MISS;
      end
      I_MISS: begin
        igrant_o = 1'b1;
        if (idone_i) state_d = RUN;
      end
      D_MISS: begin
        dgrant_o = 1'b1;
        if (ddone_i) state_d = RUN;
      end
      ID_MISS: begin
        dgrant_o = 1'b1;
        if (ddone_i) state_d = I_MISS;
      end
      default: state_d = RUN;
    endcase
  end

  // The miss cycle itself is frozen, before the FSM has left RUN.
  assign freeze_o = (state_q != RUN) || imiss_i || dmiss_i;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch stalls, flushes, cache-miss freeze.
// Latency: all controls combinational from current stage state; only miss state is registered.
// Backpressure: stalls/freeze hold stage registers; optional perf counters via HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] rs_d_i,
  input  logic [REG_ADDR_W-1:0] rt_d_i,
  input  logic [1:0]            branch_d_i,
  input  logic                  jr_d_i,
  input  logic                  jump_taken_d_i,
  input  logic                  pc_src_d_i,
  input  logic [REG_ADDR_W-1:0] rs_e_i,
  input  logic [REG_ADDR_W-1:0] rt_e_i,
  input  logic [REG_ADDR_W-1:0] write_reg_e_i,
  input  logic                  reg_write_e_i,
  input  logic                  mem_to_reg_e_i,
  input  logic [REG_ADDR_W-1:0] write_reg_m_i,
  input  logic                  reg_write_m_i,
  input  logic                  mem_to_reg_m_i,
  input  logic [REG_ADDR_W-1:0] write_reg_w_i,
  input  logic                  reg_write_w_i,
  input  logic                  imiss_i,
  input  logic                  dmiss_i,
  input  logic                  idone_i,
  input  logic                  ddone_i,
  output logic                  igrant_o,
  output logic                  dgrant_o,
  output logic                  forward_a_d_o,
  output logic                  forward_b_d_o,
  output logic [1:0]            forward_a_e_o,
  output logic [1:0]            forward_b_e_o,
  output logic                  stall_f_o,
  output logic                  stall_d_o,
  output logic                  stall_e_o,
  output logic                  stall_m_o,
  output logic                  stall_w_o,
  output logic                  flush_d_o,
  output logic                  flush_e_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      miss_cycles_o
`endif
);

  // Register 0 is hard-wired zero, so it never produces a hazard or a forward.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst,
                                     input logic                  we);
    return we && (src != '0) && (src == dst);
  endfunction

  logic     igrant, dgrant, freeze;
  logic     lw_stall, br_stall, hz, stall_d;
  fwd_sel_e fwd_a_e, fwd_b_e;

  miss_arbiter u_miss_arbiter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .imiss_i  (imiss_i),
    .dmiss_i  (dmiss_i),
    .idone_i  (idone_i),
    .ddone_i  (ddone_i),
    .igrant_o (igrant),
    .dgrant_o (dgrant),
    .freeze_o (freeze)
  );

  // Execute-stage forwarding: the younger producer in M wins over W.
  always_comb begin
    fwd_a_e = FWD_NONE;
    fwd_b_e = FWD_NONE;
    if (reg_match(rs_e_i, write_reg_m_i, reg_write_m_i))      fwd_a_e = FWD_MEM;
    else if (reg_match(rs_e_i, write_reg_w_i, reg_write_w_i)) fwd_a_e = FWD_WB;
    if (reg_match(rt_e_i, write_reg_m_i, reg_write_m_i))      fwd_b_e = FWD_MEM;
    else if (reg_match(rt_e_i, write_reg_w_i, reg_write_w_i)) fwd_b_e = FWD_WB;
  end

  // Load-use and branch-operand hazards; a branch resolved in D cannot take a value still in E
  // or a load still in M, and jr only reads rs.
  always_comb begin
    lw_stall = mem_to_reg_e_i && (rt_e_i != '0) && ((rt_e_i == rs_d_i) || (rt_e_i == rt_d_i));
    br_stall = 1'b0;
    if (branch_d_i != 2'b00)
      br_stall = reg_match(rs_d_i, write_reg_e_i, reg_write_e_i)
              || reg_match(rt_d_i, write_reg_e_i, reg_write_e_i)
              || reg_match(rs_d_i, write_reg_m_i, mem_to_reg_m_i)
              || reg_match(rt_d_i, write_reg_m_i, mem_to_reg_m_i);
    if (jr_d_i)
      br_stall = br_stall
              || reg_match(rs_d_i, write_reg_e_i, reg_write_e_i)
              || reg_match(rs_d_i, write_reg_m_i, mem_to_reg_m_i);
    hz      = lw_stall || br_stall;
    stall_d = hz || freeze;
  end

  // Everything is forced low while reset is held.
  assign igrant_o      = igrant && !rst_i;
  assign dgrant_o      = dgrant && !rst_i;
  assign forward_a_d_o = reg_match(rs_d_i, write_reg_m_i, reg_write_m_i) && !rst_i;
  assign forward_b_d_o = reg_match(rt_d_i, write_reg_m_i, reg_write_m_i) && !rst_i;
  assign forward_a_e_o = rst_i ? FWD_NONE : fwd_a_e;
  assign forward_b_e_o = rst_i ? FWD_NONE : fwd_b_e;
  assign stall_f_o     = stall_d && !rst_i;
  assign stall_d_o     = stall_d && !rst_i;
  assign stall_e_o     = freeze && !rst_i;
  assign stall_m_o     = freeze && !rst_i;
  assign stall_w_o     = freeze && !rst_i;
  assign flush_e_o     = hz && !freeze && !rst_i;
  assign flush_d_o     = (pc_src_d_i || jump_taken_d_i) && !stall_d && !rst_i;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, miss_cnt_q;

  // Saturating event counters: hazard bubbles and frozen cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      if (hz && !freeze && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (freeze && (miss_cnt_q != '1))         miss_cnt_q  <= miss_cnt_q + 1'b1;
    end
  end

  assign stall_cycles_o = rst_i ? '0 : stall_cnt_q;
  assign miss_cycles_o  = rst_i ? '0 : miss_cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
